fios_carry_normalizer: RTL and testbench

- Downstream of the cascaded DSP58 column chain in the FIOS multiplier.
- Consumes the 34-bit column sums (DSP P_o, least significant column first), propagates carries, and emits normalised 17-bit result words followed by two carry-flush words.
- Output side uses a valid/ready handshake with a 2-entry output buffer, so DSP-side back-pressure is a single ready signal.

---
 rtl/fios_carry_normalizer.sv | 189 ++++++++++++++++++
 tb/tb_fios_carry_normalizer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fios_carry_normalizer.sv
// fios_carry_normalizer: carry propagation stage behind the FIOS DSP column chain.
// Takes 2*WIDTH-bit column sums (least significant column first), adds the running
// carry, and emits WIDTH-bit normalised words followed by two carry-flush words.
// The output side is a 2-entry buffer, so the only back-pressure towards the DSP
// chain is col_ready_o.
//
// Ports:
//   clock_i       rising-edge clock
//   reset_i       synchronous active-high reset
//   col_valid_i   column sum present on col_i
//   col_ready_o   column is accepted this cycle when valid
//   col_i         2*WIDTH-bit column sum
//   col_last_i    final column of the operation
//   word_valid_o  word_o holds a result word
//   word_ready_i  consumer takes word_o this cycle when valid
//   word_o        normalised WIDTH-bit result word
//   word_last_o   marks the second (final) flush word
//   busy_o        operation in progress (first column .. last word accepted)
//   len_error_o   sticky column-count mismatch flag
module fios_carry_normalizer #(
  parameter int unsigned WORD_COUNT = 4,
  parameter int unsigned WIDTH      = 17
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 col_valid_i,
  output logic                 col_ready_o,
  input  logic [2*WIDTH-1:0]   col_i,
  input  logic                 col_last_i,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic [WIDTH-1:0]     word_o,
  output logic                 word_last_o,
  output logic                 busy_o,
  output logic                 len_error_o
);

  localparam int unsigned COL_W   = 2 * WIDTH;
  localparam int unsigned SUM_W   = COL_W + 1;
  localparam int unsigned CARRY_W = WIDTH + 1;
  localparam int unsigned ENT_W   = WIDTH + 1;
  // One spare bit so the saturating counter can sit above WORD_COUNT.
  localparam int unsigned CNT_W   = $clog2(WORD_COUNT + 1) + 1;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FLUSH0 = 2'd1,
    FLUSH1 = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [CARRY_W-1:0]   carry_q, carry_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n, cnt_inc;
  logic                 err_q, err_n;
  logic                 busy_q, busy_n;
  logic                 ready_q, ready_n;
  logic                 valid_q, valid_n;
  logic [1:0]           occ_q, occ_n;
  logic [ENT_W-1:0]     slot0_q, slot0_n;
  logic [ENT_W-1:0]     slot1_q, slot1_n;

  logic [SUM_W-1:0]     sum;
  logic                 col_xfer;
  logic                 word_xfer;
  logic                 space;
  logic                 push;
  logic [ENT_W-1:0]     push_ent;

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ACCUM;
      carry_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      occ_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_n;
      carry_q <= carry_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      ready_q <= ready_n;
      valid_q <= valid_n;
      occ_q   <= occ_n;
      slot0_q <= slot0_n;
      slot1_q <= slot1_n;
    end
  end

  // Next-state, carry arithmetic, length check and output buffer.
  always_comb begin
    state_n  = state_q;
    carry_n  = carry_q;
    cnt_n    = cnt_q;
    err_n    = err_q;
    busy_n   = busy_q;
    occ_n    = occ_q;
    slot0_n  = slot0_q;
    slot1_n  = slot1_q;
    push     = 1'b0;
    push_ent = '0;

    sum       = SUM_W'(col_i) + SUM_W'(carry_q);
    col_xfer  = col_valid_i & ready_q;
    word_xfer = valid_q & word_ready_i;
    space     = (occ_q != 2'd2);
    // Saturates so an overlong operation cannot wrap back onto WORD_COUNT.
    cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ACCUM: begin
        if (col_xfer) begin
          push     = 1'b1;
          push_ent = {1'b0, sum[WIDTH-1:0]};
          carry_n  = sum[SUM_W-1:WIDTH];
          cnt_n    = cnt_inc;
          // Flags both an early last and a missing last on the WORD_COUNT-th column.
          if (col_last_i != (cnt_inc == CNT_W'(WORD_COUNT))) begin
            err_n = 1'b1;
          end
          if (col_last_i) begin
            state_n = FLUSH0;
          end
        end
      end
      FLUSH0: begin
        if (space) begin
          push     = 1'b1;
          push_ent = {1'b0, carry_q[WIDTH-1:0]};
          state_n  = FLUSH1;
        end
      end
      FLUSH1: begin
        if (space) begin
          push     = 1'b1;
          push_ent = {1'b1, WIDTH'(carry_q[WIDTH])};
          carry_n  = '0;
          cnt_n    = '0;
          state_n  = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase

    // A new column keeps busy high even if the previous last word leaves now.
    if (col_xfer) begin
      busy_n = 1'b1;
    end else if (word_xfer && slot0_q[WIDTH]) begin
      busy_n = 1'b0;
    end

    // Slot0 is the head; push-and-pop only happens at occupancy 1.
    case ({push, word_xfer})
      2'b10: begin
        if (occ_q == 2'd0) begin
          slot0_n = push_ent;
        end else begin
          slot1_n = push_ent;
        end
        occ_n = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_n = slot1_q;
        occ_n   = occ_q - 2'd1;
      end
      2'b11: begin
        slot0_n = push_ent;
      end
      default: ;
    endcase

    ready_n = (state_n == ACCUM) && (occ_n != 2'd2);
    valid_n = (occ_n != 2'd0);
  end

  assign col_ready_o  = ready_q;
  assign word_valid_o = valid_q;
  assign word_o       = slot0_q[WIDTH-1:0];
  assign word_last_o  = slot0_q[WIDTH];
  assign busy_o       = busy_q;
  assign len_error_o  = err_q;

endmodule

// File: tb/tb_fios_carry_normalizer.sv
// Directed and randomised bench for fios_carry_normalizer (WORD_COUNT=4, WIDTH=17).
module tb_fios_carry_normalizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        col_valid;
  logic        col_ready;
  logic [33:0] col;
  logic        col_last;
  logic        word_valid;
  logic        word_ready;
  logic [16:0] word;
  logic        word_last;
  logic        busy;
  logic        len_error;

  int checks = 0;
  int errors = 0;

  logic [33:0] cols [0:63];
  logic [34:0] col_q [$];
  logic [17:0] exp_q [$];

  fios_carry_normalizer #(.WORD_COUNT(4), .WIDTH(17)) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .col_valid_i  (col_valid),
    .col_ready_o  (col_ready),
    .col_i        (col),
    .col_last_i   (col_last),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .word_o       (word),
    .word_last_o  (word_last),
    .busy_o       (busy),
    .len_error_o  (len_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the operation's integer is sum(col_i * 2^(17i)); words are its base-2^17 digits.
  task automatic queue_op(input int n, input bit with_last);
    logic [159:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      acc = acc + (160'(cols[i]) << (17 * i));
      col_q.push_back({(with_last && (i == n - 1)), cols[i]});
    end
    for (int k = 0; k < n; k++) exp_q.push_back({1'b0, acc[17*k +: 17]});
    if (with_last) begin
      exp_q.push_back({1'b0, acc[17*n +: 17]});
      exp_q.push_back({1'b1, acc[17*(n+1) +: 17]});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; col_valid = 1'b0; col = '0; col_last = 1'b0; word_ready = 1'b0;
    col_q.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_word_valid", word_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_len_error", len_error, 0);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives queued columns and sinks/compares words with the given valid/ready percentages.
  task automatic run(input int vpct, input int rpct, input bit chk_lat, input bit chk_idle);
    int cyc = 0;
    int first_in = -1;
    int first_out = -1;
    logic [17:0] e;
    while ((col_q.size() != 0 || exp_q.size() != 0) && cyc < 2000) begin
      if (col_q.size() != 0 && $urandom_range(99) < vpct) begin
        col_valid = 1'b1; col = col_q[0][33:0]; col_last = col_q[0][34];
      end else begin
        col_valid = 1'b0; col = '0; col_last = 1'b0;
      end
      word_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (word_valid && word_ready) begin
        check("busy_during_op", busy, 1);
        if (exp_q.size() == 0) begin
          check("extra_word", word_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("word", word, e[16:0]);
          check("word_last", word_last, e[17]);
        end
        if (first_out < 0) first_out = cyc;
      end
      if (col_valid && col_ready) begin
        void'(col_q.pop_front());
        if (first_in < 0) first_in = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    col_valid = 1'b0; col = '0; col_last = 1'b0; word_ready = 1'b1;
    check("pending_cols", col_q.size(), 0);
    check("pending_words", exp_q.size(), 0);
    if (chk_lat) check("latency", first_out - first_in, 1);
    if (chk_idle) begin
      @(negedge clk);
      check("busy_idle", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  // Four all-ones columns; digits worked out by hand:
  // 2^85 + 2^68 - 2^17 - 1 -> 1FFFF,1FFFE,1FFFF,1FFFF,00000,00001.
  task automatic queue_ones_op();
    for (int i = 0; i < 4; i++) col_q.push_back({(i == 3), 34'h3_FFFF_FFFF});
    exp_q.push_back(18'h1FFFF);
    exp_q.push_back(18'h1FFFE);
    exp_q.push_back(18'h1FFFF);
    exp_q.push_back(18'h1FFFF);
    exp_q.push_back(18'h00000);
    exp_q.push_back({1'b1, 17'h00001});
  endtask

  initial begin
    int acc_cnt;
    reset = 1'b1; col_valid = 1'b0; col = '0; col_last = 1'b0; word_ready = 1'b0;

    // Reset state.
    do_reset();
    check("idle_col_ready", col_ready, 1);

    // All-ones columns, full-rate handshake, first word one cycle after acceptance.
    queue_ones_op();
    run(100, 100, 1, 1);

    // All-zero operation: six zero words, last on the sixth only.
    for (int i = 0; i < 4; i++) col_q.push_back({(i == 3), 34'h0});
    for (int i = 0; i < 5; i++) exp_q.push_back(18'h0);
    exp_q.push_back({1'b1, 17'h0});
    run(100, 100, 1, 1);
    check("zero_len_error", len_error, 0);

    // Back-pressure: consumer stalled for 5 cycles while columns are offered.
    do_reset();
    for (int i = 0; i < 4; i++) cols[i] = 34'($urandom) ^ (34'($urandom_range(3)) << 32);
    queue_op(4, 1);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      col_valid = 1'b1; col = col_q[0][33:0]; col_last = col_q[0][34]; word_ready = 1'b0;
      @(negedge clk);
      if (col_ready) begin
        acc_cnt++;
        void'(col_q.pop_front());
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", acc_cnt, 2);
    check("bp_col_ready", col_ready, 0);
    check("bp_head_valid", word_valid, 1);
    check("bp_head_word", word, exp_q[0][16:0]);
    @(posedge clk); #1;
    run(100, 100, 0, 1);

    // Random operations with random valid/ready gaps.
    for (int op = 0; op < 200; op++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) cols[i] = 34'h3_FFFF_FFFF;
        else cols[i] = 34'({$urandom, $urandom});
      end
      queue_op(4, 1);
      run($urandom_range(100, 30), $urandom_range(100, 30), 0, 1);
    end
    check("rand_len_error", len_error, 0);

    // Early last on column 3: error flagged, flush words still emitted.
    do_reset();
    for (int i = 0; i < 3; i++) cols[i] = 34'({$urandom, $urandom});
    queue_op(3, 1);
    run(100, 100, 0, 1);
    check("early_last_err", len_error, 1);

    // Fourth column without last: error flagged, normalisation carries on, no flush.
    do_reset();
    for (int i = 0; i < 4; i++) cols[i] = 34'({$urandom, $urandom});
    queue_op(4, 0);
    run(100, 100, 0, 0);
    check("missing_last_err", len_error, 1);
    check("missing_last_busy", busy, 1);

    // Reset mid-operation after two columns, then a clean operation.
    do_reset();
    col_q.push_back({1'b0, 34'h3_FFFF_FFFF});
    col_q.push_back({1'b0, 34'h3_FFFF_FFFF});
    for (int i = 0; i < 10 && col_q.size() != 0; i++) begin
      col_valid = 1'b1; col = col_q[0][33:0]; col_last = 1'b0; word_ready = 1'b0;
      @(negedge clk);
      if (col_ready) void'(col_q.pop_front());
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
    @(negedge clk);
    check("midop_cols_taken", col_q.size(), 0);
    check("midop_busy", busy, 1);
    check("midop_valid", word_valid, 1);
    @(posedge clk); #1;
    do_reset();
    queue_ones_op();
    run(100, 100, 0, 1);
    check("post_reset_len_error", len_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
